reg_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer that drives the 4×8-bit register group (two read ports `s`/`d`, one write port, negedge write). It fetches 8-bit instructions from an external combinational program memory and decodes them. It executes them through an internal 8-bit ALU and issues register-group read selects and write strobes. It sits between the program ROM and the register group and is the only master of the register group's `we`/`sr`/`dr`/`i` inputs.

---
 rtl/reg_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_reg_seq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_seq_ctrl.sv
// Multi-cycle sequencer: fetches 8-bit instructions, runs them through an 8-bit ALU, drives the 4x8 register group.
// Latency FETCH->FETCH: NOP 2, ALU/MOV 4, LDI 5, JMP/JZ 4; no backpressure, start is ignored while busy.
module reg_seq_ctrl #(
    parameter logic [7:0] PROG_START = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic       rf_we,
    output logic [1:0] rf_sr,
    output logic [1:0] rf_dr,
    output logic [7:0] rf_i,
    input  logic [7:0] rf_s,
    input  logic [7:0] rf_d,
    output logic       busy,
    output logic       halted,
    output logic       zf,
    output logic       cf
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_IMM    = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_imm;
    logic [7:0] r_res;
    logic       r_zf;
    logic       r_cf;
    logic       r_we;

    logic [3:0] w_opc;
    logic [7:0] w_pc_nxt;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_alu_res;
    logic       w_alu_cf;
    logic       w_res_upd;
    logic       w_flag_upd;

    assign w_opc  = r_ir[7:4];
    assign w_sum  = {1'b0, rf_d} + {1'b0, rf_s};
    // Bit 8 of the widened difference is the borrow (set exactly when d < s).
    assign w_diff = {1'b0, rf_d} - {1'b0, rf_s};

    always_comb begin
        w_alu_res  = r_res;
        w_alu_cf   = r_cf;
        w_res_upd  = 1'b0;
        w_flag_upd = 1'b0;
        case (w_opc)
            OP_MOV: begin
                w_alu_res = rf_s;
                w_res_upd = 1'b1;
            end
            OP_ADD: begin
                w_alu_res  = w_sum[7:0];
                w_alu_cf   = w_sum[8];
                w_res_upd  = 1'b1;
                w_flag_upd = 1'b1;
            end
            OP_SUB: begin
                w_alu_res  = w_diff[7:0];
                w_alu_cf   = w_diff[8];
                w_res_upd  = 1'b1;
                w_flag_upd = 1'b1;
            end
            OP_AND: begin
                w_alu_res  = rf_d & rf_s;
                w_alu_cf   = 1'b0;
                w_res_upd  = 1'b1;
                w_flag_upd = 1'b1;
            end
            OP_OR: begin
                w_alu_res  = rf_d | rf_s;
                w_alu_cf   = 1'b0;
                w_res_upd  = 1'b1;
                w_flag_upd = 1'b1;
            end
            OP_LDI: begin
                w_alu_res = r_imm;
                w_res_upd = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_pc_nxt = r_pc;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_next   = S_FETCH;
                    w_pc_nxt = PROG_START;
                end
            end
            S_FETCH: begin
                w_next   = S_DECODE;
                w_pc_nxt = r_pc + 8'd1;
            end
            S_DECODE: begin
                case (w_opc)
                    OP_LDI, OP_JMP, OP_JZ:                 w_next = S_IMM;
                    OP_HALT:                               w_next = S_HALT;
                    OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: w_next = S_EXEC;
                    default:                               w_next = S_FETCH;
                endcase
            end
            S_IMM: begin
                w_next   = S_EXEC;
                w_pc_nxt = r_pc + 8'd1;
            end
            S_EXEC: begin
                if (w_opc == OP_JMP) begin
                    w_next   = S_FETCH;
                    w_pc_nxt = r_imm;
                end else if (w_opc == OP_JZ) begin
                    w_next = S_FETCH;
                    if (r_zf) begin
                        w_pc_nxt = r_imm;
                    end
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                w_next = S_FETCH;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= 8'h00;
            r_ir    <= 8'h00;
            r_imm   <= 8'h00;
            r_res   <= 8'h00;
            r_zf    <= 1'b0;
            r_cf    <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_nxt;
            r_we    <= (w_next == S_WB);
            if (r_state == S_FETCH) begin
                r_ir <= mem_data;
            end
            if (r_state == S_IMM) begin
                r_imm <= mem_data;
            end
            // RES and the IR-derived selects only move outside WB, so they hold steady across the write edge.
            if (r_state == S_EXEC) begin
                if (w_res_upd) begin
                    r_res <= w_alu_res;
                end
                if (w_flag_upd) begin
                    r_zf <= (w_alu_res == 8'h00);
                    r_cf <= w_alu_cf;
                end
            end
        end
    end

    assign mem_addr = r_pc;
    assign rf_we    = r_we;
    assign rf_sr    = r_ir[1:0];
    assign rf_dr    = r_ir[3:2];
    assign rf_i     = r_res;
    assign busy     = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted   = (r_state == S_HALT);
    assign zf       = r_zf;
    assign cf       = r_cf;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Bench for reg_seq_ctrl: behavioural ROM and register group, ISA-level model feeding a write scoreboard.
`timescale 1ns/1ps
module tb_reg_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       start2;
    logic [7:0] mem_addr, mem_data, rf_i, rf_s, rf_d;
    logic       rf_we, busy, halted, zf, cf;
    logic [1:0] rf_sr, rf_dr;
    logic [7:0] mem_addr2, mem_data2, rf_i2;
    logic       rf_we2, busy2, halted2, zf2, cf2;
    logic [1:0] rf_sr2, rf_dr2;

    logic [7:0] rom  [256];
    logic [7:0] rom2 [256];
    logic [7:0] regs   [4] = '{default: 8'h00};
    logic [7:0] m_regs [4] = '{default: 8'h00};
    logic       m_zf = 1'b0;
    logic       m_cf = 1'b0;

    logic [9:0] exp_q [$];
    logic [9:0] obs [64];
    int         we_cnt = 0;
    int         obs_rd = 0;
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] prog [$];

    reg_seq_ctrl #(.PROG_START(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .rf_we(rf_we), .rf_sr(rf_sr), .rf_dr(rf_dr), .rf_i(rf_i),
        .rf_s(rf_s), .rf_d(rf_d),
        .busy(busy), .halted(halted), .zf(zf), .cf(cf)
    );

    reg_seq_ctrl #(.PROG_START(8'hFE)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .mem_addr(mem_addr2), .mem_data(mem_data2),
        .rf_we(rf_we2), .rf_sr(rf_sr2), .rf_dr(rf_dr2), .rf_i(rf_i2),
        .rf_s(8'h00), .rf_d(8'h00),
        .busy(busy2), .halted(halted2), .zf(zf2), .cf(cf2)
    );

    assign mem_data  = rom[mem_addr];
    assign mem_data2 = rom2[mem_addr2];
    assign rf_s      = regs[rf_sr];
    assign rf_d      = regs[rf_dr];

    // Register group writes on the falling edge; every write is also logged for the scoreboard.
    always @(negedge clk) begin
        if (rf_we) begin
            regs[rf_dr]       <= rf_i;
            obs[we_cnt[5:0]]  <= {rf_dr, rf_i};
            we_cnt            <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load();
        for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
        for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
    endtask

    task automatic m_wr(input logic [1:0] dr, input logic [7:0] v);
        m_regs[dr] = v;
        exp_q.push_back({dr, v});
    endtask

    // Instruction-level reference: expected writes, final flags and cycles from start to HALT.
    task automatic model_run(input logic [7:0] pc0, output int cyc);
        logic [7:0] pc, ir, d, s, v;
        logic [8:0] t;
        logic       done;
        pc = pc0; cyc = 0; done = 1'b0;
        for (int n = 0; n < 64 && !done; n++) begin
            ir = rom[pc]; pc = pc + 8'd1;
            d = m_regs[ir[3:2]]; s = m_regs[ir[1:0]];
            case (ir[7:4])
                4'h1: begin m_wr(ir[3:2], s); cyc += 4; end
                4'h2: begin
                    t = {1'b0, d} + {1'b0, s};
                    m_cf = t[8]; m_zf = (t[7:0] == 8'h00);
                    m_wr(ir[3:2], t[7:0]); cyc += 4;
                end
                4'h3: begin
                    v = d - s; m_cf = (d < s); m_zf = (v == 8'h00);
                    m_wr(ir[3:2], v); cyc += 4;
                end
                4'h4: begin v = d & s; m_cf = 1'b0; m_zf = (v == 8'h00); m_wr(ir[3:2], v); cyc += 4; end
                4'h5: begin v = d | s; m_cf = 1'b0; m_zf = (v == 8'h00); m_wr(ir[3:2], v); cyc += 4; end
                4'h6: begin v = rom[pc]; pc = pc + 8'd1; m_wr(ir[3:2], v); cyc += 5; end
                4'h7: begin v = rom[pc]; pc = v; cyc += 4; end
                4'h8: begin v = rom[pc]; pc = pc + 8'd1; if (m_zf) pc = v; cyc += 4; end
                4'hF: begin cyc += 2; done = 1'b1; end
                default: cyc += 2;
            endcase
        end
    endtask

    task automatic check_writes(input string tag);
        logic [9:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < we_cnt) begin
                chk({tag, "_write"}, {22'd0, obs[obs_rd[5:0]]}, {22'd0, e});
                obs_rd++;
            end else begin
                chk({tag, "_write_missing"}, we_cnt, obs_rd + 1);
            end
        end
        chk({tag, "_write_count"}, we_cnt, obs_rd);
    endtask

    task automatic run_prog(input string tag, input int probe_cyc, input logic [7:0] probe_addr);
        int mc, c;
        model_run(8'h00, mc);
        start = 1'b1; tick(); start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        c = 0;
        while (!halted && c < 400) begin
            tick(); c++;
            if (c == probe_cyc) chk({tag, "_next_addr"}, mem_addr, probe_addr);
        end
        chk({tag, "_cycles_to_halt"}, c, mc);
        chk({tag, "_zf"}, zf, m_zf);
        chk({tag, "_cf"}, cf, m_cf);
        check_writes(tag);
    endtask

    initial begin
        int mc, c;
        logic [7:0] old_r1;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        prog = '{8'hF0}; load();
        for (int i = 0; i < 256; i++) rom2[i] = 8'hF0;
        rom2[8'hFE] = 8'h00; rom2[8'hFF] = 8'h00; rom2[8'h00] = 8'hF0;
        #12;
        chk("rst_we", rf_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_i", rf_i, 0);
        chk("rst_sel", {rf_sr, rf_dr}, 0);
        chk("rst_flags", {zf, cf}, 0);
        chk("rst_wrap_addr", mem_addr2, 0);
        tick(); rst_n = 1'b1; tick();

        // LDI r1,5; LDI r2,3; ADD r1,r2; HALT -> 16 cycles
        prog = '{8'h64, 8'h05, 8'h68, 8'h03, 8'h26, 8'hF0}; load();
        run_prog("basic", 0, 8'h00);
        chk("basic_r1", regs[1], 8'h08);
        chk("basic_r2", regs[2], 8'h03);

        prog = '{8'h60, 8'hFF, 8'h64, 8'h01, 8'h21, 8'hF0}; load();
        run_prog("add_ovf", 0, 8'h00);
        chk("add_ovf_r0", regs[0], 8'h00);

        prog = '{8'h31, 8'hF0}; load();
        run_prog("sub_borrow", 0, 8'h00);
        chk("sub_borrow_r0", regs[0], 8'hFF);

        prog = '{8'h80, 8'h10, 8'h00, 8'hF0}; load();
        run_prog("jz_not_taken", 4, 8'h02);

        prog = '{8'h6C, 8'h00, 8'h4F, 8'h80, 8'h10}; load();
        run_prog("jz_taken", 13, 8'h10);

        start2 = 1'b1; tick(); start2 = 1'b0;
        chk("wrap_addr_fe", mem_addr2, 8'hFE);
        tick(); tick();
        chk("wrap_addr_ff", mem_addr2, 8'hFF);
        tick(); tick();
        chk("wrap_addr_00", mem_addr2, 8'h00);
        tick(); tick();
        chk("wrap_halted", halted2, 1);
        chk("wrap_no_write", rf_we2, 0);

        prog = '{8'h00, 8'h00, 8'h00, 8'hF0}; load();
        model_run(8'h00, mc);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("restart_addr_before", mem_addr, 8'h01);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("restart_ignored_addr", mem_addr, 8'h02);
        chk("restart_ignored_busy", busy, 1);
        c = 4;
        while (!halted && c < 400) begin tick(); c++; end
        chk("restart_cycles_to_halt", c, mc);
        check_writes("restart");

        prog = '{8'h64, 8'h55, 8'hF0}; load();
        old_r1 = regs[1];
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("rstwb_in_wb", rf_we, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstwb_we", rf_we, 0);
        chk("rstwb_busy", busy, 0);
        chk("rstwb_halted", halted, 0);
        chk("rstwb_addr", mem_addr, 0);
        chk("rstwb_i", rf_i, 0);
        chk("rstwb_sel", {rf_sr, rf_dr}, 0);
        chk("rstwb_flags", {zf, cf}, 0);
        tick(); rst_n = 1'b1; m_zf = 1'b0; m_cf = 1'b0; tick();
        chk("rstwb_r1_kept", regs[1], old_r1);
        check_writes("rstwb");

        prog = '{8'h60, 8'hFF, 8'h64, 8'h01, 8'h21, 8'hA5, 8'hF0}; load();
        run_prog("undef_op", 0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
